// File: rtl/issue_age_select_if.sv
// Bundle of the scheduler's control, rename and execute signals.
// The master side is the environment (rename/execute); the slave side is the scheduler.
interface issue_age_select_if #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned IDX_W   = 5
);
  logic               FLUSH;
  logic               STALL;
  logic               alloc_valid;
  logic [IDX_W-1:0]   alloc_idx;
  logic [ENTRIES-1:0] ready_vec;
  logic [IDX_W-1:0]   free_idx;
  logic               full;
  logic [IDX_W-1:0]   occ_count;
  logic               grant_valid;
  logic [IDX_W-1:0]   grant_idx;
  logic [ENTRIES-1:0] grant_onehot;
  logic               alloc_err;

  modport master (
    output FLUSH, STALL, alloc_valid, alloc_idx, ready_vec,
    input  free_idx, full, occ_count, grant_valid, grant_idx, grant_onehot, alloc_err
  );

  modport slave (
    input  FLUSH, STALL, alloc_valid, alloc_idx, ready_vec,
    output free_idx, full, occ_count, grant_valid, grant_idx, grant_onehot, alloc_err
  );
endinterface

// File: rtl/issue_age_select.sv
// Oldest-first select scheduler for the out-of-order issue queue.
// An age matrix records allocation order; each cycle the oldest ready entry is
// granted through registered outputs, and the lowest free slot is offered to rename.
module issue_age_select #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned IDX_W   = 5
) (
  input  logic CLK,
  input  logic RESET,
  issue_age_select_if.slave bus
);

  localparam int unsigned      SLOT_W = $clog2(ENTRIES);
  localparam logic [IDX_W-1:0] NONE   = IDX_W'(ENTRIES);

  // r_older[i][j]: slot i was allocated before slot j (meaningful only if both valid)
  logic [ENTRIES-1:0] r_valid;
  logic [ENTRIES-1:0] r_older [ENTRIES];
  logic               r_grant_valid;
  logic [IDX_W-1:0]   r_grant_idx;
  logic [ENTRIES-1:0] r_grant_onehot;
  logic [IDX_W-1:0]   r_occ_count;
  logic               r_alloc_err;

  logic [ENTRIES-1:0] w_cand;
  logic [ENTRIES-1:0] w_sel;
  logic [IDX_W-1:0]   w_sel_idx;
  logic [IDX_W-1:0]   w_free_idx;
  logic               w_issue;
  logic [SLOT_W-1:0]  w_alloc_slot;
  logic               w_alloc_ok;
  logic [ENTRIES-1:0] w_valid_d;
  logic [ENTRIES-1:0] w_older_d [ENTRIES];
  logic [IDX_W-1:0]   w_occ_d;

  // Oldest-ready select: a candidate wins when no other candidate is older than it.
  always_comb begin
    w_cand    = r_valid & bus.ready_vec;
    w_sel     = '0;
    w_sel_idx = NONE;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      logic blocked;
      blocked = 1'b0;
      for (int j = 0; j < int'(ENTRIES); j++) begin
        if (w_cand[j] && r_older[j][i]) blocked = 1'b1;
      end
      w_sel[i] = w_cand[i] & ~blocked;
    end
    for (int i = 0; i < int'(ENTRIES); i++) begin
      if (w_sel[i]) w_sel_idx = IDX_W'(i);
    end
  end

  // Lowest-index empty slot, or NONE when every slot is occupied.
  always_comb begin
    w_free_idx = NONE;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (!r_valid[i]) w_free_idx = IDX_W'(i);
    end
  end

  // Alloc acceptance uses pre-edge occupancy, so a slot granted this edge is still busy.
  always_comb begin
    w_issue      = !bus.STALL && (|w_cand);
    w_alloc_slot = bus.alloc_idx[SLOT_W-1:0];
    w_alloc_ok   = bus.alloc_valid && (bus.alloc_idx < NONE) && !r_valid[w_alloc_slot];
  end

  // Next occupancy and age state from the grant and accepted alloc.
  always_comb begin
    w_valid_d = r_valid;
    w_older_d = r_older;
    if (w_issue) w_valid_d = w_valid_d & ~w_sel;
    if (w_alloc_ok) begin
      w_valid_d[w_alloc_slot] = 1'b1;
      w_older_d[w_alloc_slot] = '0;
      // Every currently valid entry becomes older than the new one.
      for (int j = 0; j < int'(ENTRIES); j++) begin
        w_older_d[j][w_alloc_slot] = r_valid[j];
      end
    end
    w_occ_d = r_occ_count + {{(IDX_W-1){1'b0}}, w_alloc_ok} - {{(IDX_W-1){1'b0}}, w_issue};
  end

  // State and registered grant; FLUSH squashes everything like reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_valid        <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) r_older[i] <= '0;
      r_grant_valid  <= 1'b0;
      r_grant_idx    <= NONE;
      r_grant_onehot <= '0;
      r_occ_count    <= '0;
      r_alloc_err    <= 1'b0;
    end else if (bus.FLUSH) begin
      r_valid        <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) r_older[i] <= '0;
      r_grant_valid  <= 1'b0;
      r_grant_idx    <= NONE;
      r_grant_onehot <= '0;
      r_occ_count    <= '0;
      r_alloc_err    <= 1'b0;
    end else begin
      r_valid        <= w_valid_d;
      for (int i = 0; i < int'(ENTRIES); i++) r_older[i] <= w_older_d[i];
      r_grant_valid  <= w_issue;
      r_grant_idx    <= w_issue ? w_sel_idx : NONE;
      r_grant_onehot <= w_issue ? w_sel : '0;
      r_occ_count    <= w_occ_d;
      r_alloc_err    <= bus.alloc_valid && !w_alloc_ok;
    end
  end

  assign bus.free_idx     = w_free_idx;
  assign bus.full         = &r_valid;
  assign bus.occ_count    = r_occ_count;
  assign bus.grant_valid  = r_grant_valid;
  assign bus.grant_idx    = r_grant_idx;
  assign bus.grant_onehot = r_grant_onehot;
  assign bus.alloc_err    = r_alloc_err;

endmodule
